// File: rtl/kitchen_pkg.sv
// Shared definitions for the kitchen game UART command/status byte format.
// Bytes are {payload[7:2], channel[1:0]}.
package kitchen_pkg;

   localparam int TGT_W = 6;

   localparam logic [1:0] CH_GAME = 2'b01;
   localparam logic [1:0] CH_OP   = 2'b10;
   localparam logic [1:0] CH_TGT  = 2'b11;

   localparam logic [5:0] PL_START = 6'b000001;
   localparam logic [5:0] PL_STOP  = 6'b000010;

   localparam int OP_GET       = 0;
   localparam int OP_PUT       = 1;
   localparam int OP_INTERACT  = 2;
   localparam int OP_MOVE_FWD  = 3;
   localparam int OP_MOVE_BACK = 4;
   localparam int OP_THROW     = 5;

   localparam logic [TGT_W-1:0] TGT_NONE = '1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } enc_state_t;

   function automatic logic is_onehot6(input logic [5:0] v);
      return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
   endfunction

   function automatic logic [7:0] encode(input logic [5:0] payload, input logic [1:0] channel);
      return {payload, channel};
   endfunction

endpackage

// File: rtl/kitchen_gap_timer.sv
// Loadable down-counter that stops at zero; zero flags the end of the gap.
module kitchen_gap_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic         zero
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - W'(1);
      end
   end

   assign zero = (count_reg == '0);

endmodule

// File: rtl/kitchen_cmd_encoder.sv
// Encodes game/operation/target requests into command bytes and hands them to
// the UART transmitter one at a time with an enforced idle gap between bytes.
module kitchen_cmd_encoder
   import kitchen_pkg::*;
#(
   parameter logic [15:0] GAP_CYCLES = 16'd1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             game_req,
   input  logic             game_start,
   input  logic             op_req,
   input  logic [5:0]       op_code,
   input  logic             tgt_req,
   input  logic [TGT_W-1:0] tgt_id,
   input  logic             tgt_force,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             drop
);

   enc_state_t       state_reg, state_next;

   logic             game_pend_reg, op_pend_reg, tgt_pend_reg;
   logic [5:0]       game_pl_reg, op_pl_reg;
   logic [TGT_W-1:0] tgt_pl_reg, last_tgt_reg;
   logic [7:0]       tx_data_reg;
   logic             tx_valid_reg, drop_reg;

   logic             op_ok, tgt_ok, drop_next;
   logic             any_pend, any_new;
   logic             sel_game, sel_tgt, sel_op;
   logic [7:0]       load_byte;
   logic             load_en, accept, gap_load, gap_zero;

   // A target request matching the last byte the UART actually took is redundant.
   assign op_ok     = op_req && is_onehot6(op_code);
   assign tgt_ok    = tgt_req && (tgt_force || (tgt_id != last_tgt_reg));
   assign drop_next = (op_req && !op_ok) || (tgt_req && !tgt_ok);

   assign any_pend = game_pend_reg || op_pend_reg || tgt_pend_reg;
   assign any_new  = game_req || op_ok || tgt_ok;

   assign sel_game = game_pend_reg;
   assign sel_tgt  = !game_pend_reg && tgt_pend_reg;
   assign sel_op   = !game_pend_reg && !tgt_pend_reg && op_pend_reg;

   always_comb begin
      load_byte = 8'h00;
      if (sel_game) begin
         load_byte = encode(game_pl_reg, CH_GAME);
      end else if (sel_tgt) begin
         load_byte = encode(tgt_pl_reg, CH_TGT);
      end else if (sel_op) begin
         load_byte = encode(op_pl_reg, CH_OP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // IDLE also reacts to a request arriving this cycle so the byte leaves two cycles after the pulse.
   always_comb begin
      state_next = state_reg;
      load_en    = 1'b0;
      accept     = 1'b0;
      gap_load   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if ((any_pend || any_new) && gap_zero) begin
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            load_en    = 1'b1;
            state_next = ST_SEND;
         end
         ST_SEND: begin
            if (tx_ready) begin
               accept     = 1'b1;
               gap_load   = 1'b1;
               state_next = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_zero) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         game_pend_reg <= 1'b0;
         op_pend_reg   <= 1'b0;
         tgt_pend_reg  <= 1'b0;
         game_pl_reg   <= '0;
         op_pl_reg     <= '0;
         tgt_pl_reg    <= '0;
         last_tgt_reg  <= TGT_NONE;
         tx_data_reg   <= 8'h00;
         tx_valid_reg  <= 1'b0;
         drop_reg      <= 1'b0;
      end else begin
         drop_reg <= drop_next;

         // A capture in the load cycle wins over clearing, so the new value stays pending.
         if (game_req) begin
            game_pend_reg <= 1'b1;
            game_pl_reg   <= game_start ? PL_START : PL_STOP;
         end else if (load_en && sel_game) begin
            game_pend_reg <= 1'b0;
         end

         if (tgt_ok) begin
            tgt_pend_reg <= 1'b1;
            tgt_pl_reg   <= tgt_id;
         end else if (load_en && sel_tgt) begin
            tgt_pend_reg <= 1'b0;
         end

         if (op_ok) begin
            op_pend_reg <= 1'b1;
            op_pl_reg   <= op_code;
         end else if (load_en && sel_op) begin
            op_pend_reg <= 1'b0;
         end

         if (load_en) begin
            tx_data_reg  <= load_byte;
            tx_valid_reg <= 1'b1;
         end else if (accept) begin
            tx_valid_reg <= 1'b0;
         end

         if (accept && (tx_data_reg[1:0] == CH_TGT)) begin
            last_tgt_reg <= tx_data_reg[7:2];
         end
      end
   end

   kitchen_gap_timer #(
      .W(16)
   ) u_gap_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (gap_load),
      .load_value (GAP_CYCLES - 16'd1),
      .zero       (gap_zero)
   );

   assign tx_data  = tx_data_reg;
   assign tx_valid = tx_valid_reg;
   assign drop     = drop_reg;
   assign busy     = (state_reg != ST_IDLE) || any_pend;

endmodule

// File: tb/tb_kitchen_cmd_encoder.sv
// Directed bench for kitchen_cmd_encoder with a per-cycle slot-based reference model.
module tb_kitchen_cmd_encoder;

   localparam logic [15:0] GAP = 16'd8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       game_req = 1'b0, game_start = 1'b0;
   logic       op_req = 1'b0;
   logic [5:0] op_code = 6'd0;
   logic       tgt_req = 1'b0, tgt_force = 1'b0;
   logic [5:0] tgt_id = 6'd0;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready = 1'b0;
   logic       busy, drop;

   always #5 clk = ~clk;

   kitchen_cmd_encoder #(.GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .game_req   (game_req),
      .game_start (game_start),
      .op_req     (op_req),
      .op_code    (op_code),
      .tgt_req    (tgt_req),
      .tgt_id     (tgt_id),
      .tgt_force  (tgt_force),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .drop       (drop)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Inputs and outputs as seen at each rising edge.
   int         cyc = 0;
   logic       s_game_req = 0, s_game_start = 0, s_op_req = 0, s_tgt_req = 0, s_tgt_force = 0;
   logic       s_valid = 0, s_ready = 0;
   logic [5:0] s_op_code = 0, s_tgt_id = 0;
   logic [7:0] s_data = 0;

   always @(posedge clk) begin
      cyc          <= cyc + 1;
      s_game_req   <= game_req;
      s_game_start <= game_start;
      s_op_req     <= op_req;
      s_op_code    <= op_code;
      s_tgt_req    <= tgt_req;
      s_tgt_id     <= tgt_id;
      s_tgt_force  <= tgt_force;
      s_valid      <= tx_valid;
      s_ready      <= tx_ready;
      s_data       <= tx_data;
   end

   // Model: one slot per channel in priority order 0=game, 1=target, 2=op.
   bit         m_pend[3];
   logic [5:0] m_val[3];
   logic [5:0] m_last = 6'h3F;
   int         last_acc = -1;
   logic [7:0] sent[$];

   always @(negedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            m_pend[i] = 1'b0;
            m_val[i]  = 6'd0;
         end
         m_last   = 6'h3F;
         last_acc = -1;
      end else begin
         bit         acc, exp_drop;
         int         w;
         logic [7:0] exp_byte;
         acc = s_valid && s_ready;
         if (acc) begin
            sent.push_back(s_data);
            $display("TX byte=%02h cycle=%0d", s_data, cyc);
            last_acc = cyc;
         end
         exp_drop = (s_op_req && !$onehot(s_op_code)) ||
                    (s_tgt_req && !s_tgt_force && (s_tgt_id == m_last));
         if (acc && (s_data[1:0] == 2'b11)) m_last = s_data[7:2];
         check(drop == exp_drop, "drop", {31'd0, drop}, {31'd0, exp_drop});

         if (tx_valid && !s_valid) begin
            w = -1;
            for (int i = 0; i < 3; i++) if (w < 0 && m_pend[i]) w = i;
            check(w >= 0, "spurious_byte", {24'd0, tx_data}, 32'd0);
            if (w >= 0) begin
               case (w)
                  0:       exp_byte = {m_val[0], 2'b01};
                  1:       exp_byte = {m_val[1], 2'b11};
                  default: exp_byte = {m_val[2], 2'b10};
               endcase
               check(tx_data == exp_byte, "byte", {24'd0, tx_data}, {24'd0, exp_byte});
               m_pend[w] = 1'b0;
            end
            if (last_acc >= 0)
               check((cyc - last_acc) >= int'(GAP), "gap", cyc - last_acc, {16'd0, GAP});
         end

         if (s_valid && !s_ready)
            check(tx_valid && (tx_data == s_data), "hold", {23'd0, tx_valid, tx_data}, {24'd1, s_data});

         if (s_game_req) begin
            m_pend[0] = 1'b1;
            m_val[0]  = s_game_start ? 6'b000001 : 6'b000010;
         end
         if (s_tgt_req && (s_tgt_force || s_tgt_id != m_last)) begin
            m_pend[1] = 1'b1;
            m_val[1]  = s_tgt_id;
         end
         if (s_op_req && $onehot(s_op_code)) begin
            m_pend[2] = 1'b1;
            m_val[2]  = s_op_code;
         end
      end
   end

   function automatic logic [7:0] sent_at(input int i);
      return (i < sent.size()) ? sent[i] : 8'h00;
   endfunction

   task automatic nstep();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_game(input bit start);
      game_req = 1'b1; game_start = start;
      @(posedge clk); #1;
      game_req = 1'b0;
   endtask

   task automatic pulse_op(input logic [5:0] code);
      op_req = 1'b1; op_code = code;
      @(posedge clk); #1;
      op_req = 1'b0;
   endtask

   task automatic pulse_tgt(input logic [5:0] id, input bit force_it);
      tgt_req = 1'b1; tgt_id = id; tgt_force = force_it;
      @(posedge clk); #1;
      tgt_req = 1'b0; tgt_force = 1'b0;
   endtask

   task automatic wait_sent(input int n, input int budget, input string name);
      int k = 0;
      while (sent.size() < n && k < budget) begin
         nstep();
         k++;
      end
      check(sent.size() >= n, name, sent.size(), n);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while ((busy || tx_valid) && k < 200) begin
         nstep();
         k++;
      end
      check(!busy && !tx_valid, name, {30'd0, busy, tx_valid}, 32'd0);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!tx_valid && k < 50) begin
         nstep();
         k++;
      end
      check(tx_valid, name, {31'd0, tx_valid}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  base;
      bit  hold_ok;

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      nstep();
      check(tx_data == 8'h00, "rst_tx_data", {24'd0, tx_data}, 32'h0);
      check(tx_valid == 1'b0, "rst_tx_valid", {31'd0, tx_valid}, 32'h0);
      check(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'h0);
      check(drop == 1'b0, "rst_drop", {31'd0, drop}, 32'h0);

      // Start byte: two-cycle latency, then a stop byte behind the gap.
      tx_ready = 1'b1;
      pulse_game(1'b1);
      nstep();
      check(!tx_valid, "t1_lat_cycle1", {31'd0, tx_valid}, 32'd0);
      nstep();
      check(tx_valid && tx_data == 8'h05, "t1_lat_cycle2", {23'd0, tx_valid, tx_data}, 32'h105);
      pulse_game(1'b0);
      wait_sent(2, 100, "t1_second_sent");
      check(sent_at(0) == 8'h05, "t1_byte0", {24'd0, sent_at(0)}, 32'h05);
      check(sent_at(1) == 8'h09, "t1_byte1", {24'd0, sent_at(1)}, 32'h09);

      // Back-pressure: byte held stable until ready.
      wait_idle("t2_idle");
      tx_ready = 1'b0;
      base = sent.size();
      pulse_op(6'b000100);
      wait_valid("t2_valid");
      hold_ok = 1'b1;
      repeat (10) begin
         nstep();
         hold_ok &= tx_valid && (tx_data == 8'h12);
      end
      check(hold_ok, "t2_hold10", {31'd0, hold_ok}, 32'd1);
      tx_ready = 1'b1;
      nstep();
      check(!tx_valid, "t2_release", {31'd0, tx_valid}, 32'd0);
      check(sent_at(base) == 8'h12, "t2_byte", {24'd0, sent_at(base)}, 32'h12);

      // Simultaneous requests leave in priority order.
      wait_idle("t3_idle");
      base = sent.size();
      game_req = 1'b1; game_start = 1'b1;
      tgt_req = 1'b1; tgt_id = 6'd5; tgt_force = 1'b0;
      op_req = 1'b1; op_code = 6'b000001;
      @(posedge clk); #1;
      game_req = 1'b0; tgt_req = 1'b0; op_req = 1'b0;
      wait_sent(base + 3, 200, "t3_three_sent");
      check(sent_at(base) == 8'h05, "t3_first", {24'd0, sent_at(base)}, 32'h05);
      check(sent_at(base + 1) == 8'h17, "t3_second", {24'd0, sent_at(base + 1)}, 32'h17);
      check(sent_at(base + 2) == 8'h06, "t3_third", {24'd0, sent_at(base + 2)}, 32'h06);

      // Duplicate target dropped unless forced.
      wait_idle("t4_idle");
      base = sent.size();
      pulse_tgt(6'd5, 1'b0);
      nstep();
      check(drop == 1'b1, "t4_drop", {31'd0, drop}, 32'd1);
      repeat (30) nstep();
      check(sent.size() == base, "t4_no_byte", sent.size(), base);
      check(!busy, "t4_busy", {31'd0, busy}, 32'd0);
      pulse_tgt(6'd5, 1'b1);
      wait_sent(base + 1, 100, "t4_forced_sent");
      check(sent_at(base) == 8'h17, "t4_forced_byte", {24'd0, sent_at(base)}, 32'h17);

      // Invalid op dropped; overwrite of a pending op during the gap.
      wait_idle("t5_idle");
      pulse_op(6'b000011);
      nstep();
      check(drop == 1'b1, "t5_drop", {31'd0, drop}, 32'd1);
      check(!busy, "t5_busy", {31'd0, busy}, 32'd0);
      base = sent.size();
      pulse_game(1'b1);
      wait_sent(base + 1, 100, "t5_game_sent");
      pulse_op(6'b000001);
      pulse_op(6'b100000);
      wait_sent(base + 2, 100, "t5_op_sent");
      check(sent_at(base) == 8'h05, "t5_game_byte", {24'd0, sent_at(base)}, 32'h05);
      check(sent_at(base + 1) == 8'h82, "t5_op_byte", {24'd0, sent_at(base + 1)}, 32'h82);
      repeat (40) nstep();
      check(sent.size() == base + 2, "t5_only_one_op", sent.size(), base + 2);

      // Reset during SEND with another request pending.
      wait_idle("t6_idle");
      tx_ready = 1'b0;
      pulse_game(1'b1);
      wait_valid("t6_valid");
      pulse_op(6'b001000);
      nstep();
      rst_n = 1'b0;
      #1;
      check(tx_valid == 1'b0, "t6_rst_valid", {31'd0, tx_valid}, 32'd0);
      check(tx_data == 8'h00, "t6_rst_data", {24'd0, tx_data}, 32'd0);
      check(busy == 1'b0, "t6_rst_busy", {31'd0, busy}, 32'd0);
      check(drop == 1'b0, "t6_rst_drop", {31'd0, drop}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      base = sent.size();
      tx_ready = 1'b1;
      repeat (3 * int'(GAP) + 10) nstep();
      check(sent.size() == base, "t6_no_spurious", sent.size(), base);
      check(!busy && !tx_valid, "t6_quiet", {30'd0, busy, tx_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
